// File: rtl/fsm_test_sequencer_pkg.sv
// Shared types and constants for the FSM test sequencer: state encoding,
// path-select codes and the table that maps a path to the branch inputs.
package fsm_seq_pkg;

  // Sequencer state encoding (2-bit, fixed values so debug taps are stable).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Path select codes carried on the mode input.
  typedef enum logic [1:0] {
    MODE_A = 2'd0,
    MODE_B = 2'd1,
    MODE_C = 2'd2,
    MODE_D = 2'd3
  } mode_e;

  // Branch inputs {x1, x2, x3} for each path, indexed by mode code.
  // Entry 3 (D) holds every input low: the stall path that never terminates.
  localparam logic [3:0][2:0] MODE_X_TABLE = '{
    3'b000,  // MODE_D
    3'b001,  // MODE_C
    3'b110,  // MODE_B
    3'b010   // MODE_A
  };

  // Look up the branch inputs for one path.
  function automatic logic [2:0] mode_to_x(input mode_e m);
    return MODE_X_TABLE[m];
  endfunction

endpackage

// File: rtl/fsm_test_sequencer_if.sv
// Bundle of job-request, job-report and controlled-FSM signals around the
// sequencer. The slave modport is the sequencer; the master modport is
// everything surrounding it (lab top / bench and the controlled FSM).
//
// Handshake: start acts as a request qualified by ready = !busy. A job is
// accepted on the rising edge where start=1 and busy=0 (sequencer in IDLE);
// mode and exp_lat are captured on that same edge. A request while busy is
// dropped, never queued. Completion is the one-cycle done pulse, with
// latency/timeout/pass valid in that cycle and held until the next accept.
interface fsm_test_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] exp_lat;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] latency;
  logic             timeout;
  logic             pass;
  logic             dut_reset;
  logic             dut_x1;
  logic             dut_x2;
  logic             dut_x3;
  logic             dut_result;

  modport master (
    output start, mode, exp_lat, dut_result,
    input  busy, done, latency, timeout, pass,
    input  dut_reset, dut_x1, dut_x2, dut_x3
  );

  modport slave (
    input  start, mode, exp_lat, dut_result,
    output busy, done, latency, timeout, pass,
    output dut_reset, dut_x1, dut_x2, dut_x3
  );
endinterface

// File: rtl/fsm_test_sequencer_run_timer.sv
// Saturation-free up counter shared by the RESET hold and the RUN latency
// measurement. The owner picks the compare limit per phase; at_limit_o tells
// it when the current count has reached that limit.
module fsm_run_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over enable; the owner never enables past limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/fsm_test_sequencer.sv
// Test sequencer for the branch-decision FSM. Each accepted job holds the
// controlled FSM in reset for RST_CYCLES cycles, then releases it with the
// branch inputs of the selected path and counts cycles until result rises
// or TIMEOUT is reached. Latency, timeout and pass are reported with a
// one-cycle done pulse and held until the next accepted job.
module fsm_test_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  fsm_test_sequencer_if.slave        bus,
  output seq_state_e                 dbg_state_o
);

  // Compare limits for the shared timer in each phase.
  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(TIMEOUT);

  seq_state_e       state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] exp_lat_q, exp_lat_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             to_q, to_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             dut_rst_q, dut_rst_d;
  logic [2:0]       x_q, x_d;

  logic             tmr_clear;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_limit;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_at_limit;

  fsm_run_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear_i    (tmr_clear),
    .enable_i   (tmr_en),
    .limit_i    (tmr_limit),
    .count_o    (tmr_count),
    .at_limit_o (tmr_at_limit)
  );

  // Next-state, job capture, result capture and timer control.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    exp_lat_d = exp_lat_q;
    lat_d     = lat_q;
    to_d      = to_q;
    pass_d    = pass_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    tmr_limit = RUN_LIM;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RESET;
          mode_d    = mode_e'(bus.mode);
          exp_lat_d = bus.exp_lat;
          lat_d     = '0;
          to_d      = 1'b0;
          pass_d    = 1'b0;
          tmr_clear = 1'b1;
        end
      end

      ST_RESET: begin
        tmr_limit = RST_LIM;
        if (tmr_at_limit) begin
          state_d   = ST_RUN;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_RUN: begin
        // An x/z result falls through to the else branches, i.e. not asserted.
        // Result is checked first so a result on the TIMEOUT edge still counts.
        if (bus.dut_result == 1'b1) begin
          state_d = ST_DONE;
          lat_d   = tmr_count;
          to_d    = 1'b0;
          pass_d  = (tmr_count == exp_lat_q);
        end else if (tmr_at_limit) begin
          state_d = ST_DONE;
          lat_d   = RUN_LIM;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered so they
  // line up exactly with the state they belong to.
  always_comb begin
    done_d    = (state_d == ST_DONE);
    dut_rst_d = (state_d != ST_RUN);
    x_d       = 3'b000;
    if (state_d == ST_RESET || state_d == ST_RUN) begin
      x_d = mode_to_x(mode_d);
    end
  end

  // State and output registers; reset leaves the controlled FSM held in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_A;
      exp_lat_q <= '0;
      lat_q     <= '0;
      to_q      <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      dut_rst_q <= 1'b1;
      x_q       <= 3'b000;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      exp_lat_q <= exp_lat_d;
      lat_q     <= lat_d;
      to_q      <= to_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      dut_rst_q <= dut_rst_d;
      x_q       <= x_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.latency   = lat_q;
  assign bus.timeout   = to_q;
  assign bus.pass      = pass_q;
  assign bus.dut_reset = dut_rst_q;
  assign bus.dut_x1    = x_q[2];
  assign bus.dut_x2    = x_q[1];
  assign bus.dut_x3    = x_q[0];
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fsm_test_sequencer.sv
// Bench for fsm_test_sequencer: a stand-in controlled FSM whose result rises
// a path-dependent number of cycles after release, a job driver, and a
// scoreboard whose monitor checks every done pulse against expectations.
module tb_fsm_test_sequencer;
  import fsm_seq_pkg::*;

  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 15;
  localparam int CNT_W      = 4;
  localparam int W          = 9;  // {x[2:0], latency[3:0], timeout, pass}

  logic       clk;
  logic       reset_n;
  seq_state_e dbg_state;

  fsm_test_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fsm_test_sequencer #(
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stand-in controlled FSM ----------------
  // Result rises plant_n cycles after release; plant_ovr >= 0 forces a delay.
  int plant_cyc;
  int plant_ovr = -1;
  int plant_n;

  always @(posedge clk) begin
    if (bus.dut_reset) plant_cyc <= 0;
    else               plant_cyc <= plant_cyc + 1;
  end

  always_comb begin
    plant_n = 1000;
    if (plant_ovr >= 0) begin
      plant_n = plant_ovr;
    end else begin
      case ({bus.dut_x1, bus.dut_x2, bus.dut_x3})
        3'b010, 3'b110: plant_n = 6;
        3'b001:         plant_n = 4;
        default:        plant_n = 1000;
      endcase
    end
  end

  assign bus.dut_result = !bus.dut_reset && (plant_cyc >= plant_n);

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input int m, input int e, input int ovr);
    int d;
    logic [2:0] x;
    logic [3:0] lat;
    logic to, ps;
    case (m)
      0:       begin d = 6;    x = 3'b010; end
      1:       begin d = 6;    x = 3'b110; end
      2:       begin d = 4;    x = 3'b001; end
      default: begin d = 1000; x = 3'b000; end
    endcase
    if (ovr >= 0) d = ovr;
    if (d <= TIMEOUT) begin lat = 4'(d);       to = 1'b0; end
    else              begin lat = 4'(TIMEOUT); to = 1'b1; end
    ps = !to && (int'(lat) == e);
    return {x, lat, to, ps};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", 32'(bus.busy), 0);
  endtask

  // Issue one job from an idle negedge; optionally register its expectation.
  task automatic run_job(input int m, input int e, input int ovr, input bit push);
    wait_idle(64);
    plant_ovr   = ovr;
    bus.mode    = 2'(m);
    bus.exp_lat = 4'(e);
    bus.start   = 1'b1;
    if (push) exp_q.push_back(model(m, e, ovr));
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_done"},      32'(bus.done), 0);
    check({tag, "_dut_reset"}, 32'(bus.dut_reset), 1);
    check({tag, "_latency"},   32'(bus.latency), 0);
    check({tag, "_timeout"},   32'(bus.timeout), 0);
    check({tag, "_pass"},      32'(bus.pass), 0);
    check({tag, "_x"},         32'({bus.dut_x1, bus.dut_x2, bus.dut_x3}), 0);
    check({tag, "_state"},     32'(dbg_state), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [2:0]   x_seen;
    logic [2:0]   x_now;
    logic         seen;
    logic         x_bad;
    int           rst_cnt;
    logic [W-1:0] e;
    seen = 1'b0; x_bad = 1'b0; rst_cnt = 0; x_seen = 3'b000;
    forever begin
      @(negedge clk);
      x_now = {bus.dut_x1, bus.dut_x2, bus.dut_x3};
      if (!reset_n) begin
        seen = 1'b0; x_bad = 1'b0; rst_cnt = 0;
      end else if (bus.done) begin
        check("job_pending_at_done", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("latency",          32'(bus.latency), 32'(e[5:2]));
          check("timeout",          32'(bus.timeout), 32'(e[1]));
          check("pass",             32'(bus.pass), 32'(e[0]));
          check("branch_inputs",    32'(x_seen), 32'(e[8:6]));
          check("inputs_stable",    32'(x_bad), 0);
          check("reset_hold_cycles", 32'(rst_cnt), RST_CYCLES);
          check("done_dut_reset",   32'(bus.dut_reset), 1);
          check("done_inputs_low",  32'(x_now), 0);
        end
        seen = 1'b0; x_bad = 1'b0; rst_cnt = 0;
      end else if (bus.busy) begin
        if (!seen) begin
          x_seen = x_now;
          seen   = 1'b1;
        end else if (x_now != x_seen) begin
          x_bad = 1'b1;
        end
        if (bus.dut_reset) rst_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int m, e, ovr;
    logic [W-1:0] tmp;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.exp_lat = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed paths.
    run_job(0, 6, -1, 1'b1);   // A: latency 6, pass
    run_job(1, 6, -1, 1'b1);   // B: latency 6, pass
    run_job(2, 5, -1, 1'b1);   // C: latency 4, fail
    run_job(3, 0, -1, 1'b1);   // D: timeout, latency 15

    // Timeout boundary: result on the TIMEOUT edge wins; one later times out.
    run_job(2, 15, 15, 1'b1);
    run_job(2, 15, 16, 1'b1);
    run_job(1, 0, 0, 1'b1);    // result already high in the first RUN cycle

    // Second start plus mode/exp_lat change mid-RUN is ignored.
    run_job(0, 6, -1, 1'b1);
    repeat (4) @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = 2'd2;
    bus.exp_lat = 4'd0;
    @(negedge clk);
    bus.start   = 1'b0;

    // Async reset mid-RUN: immediate return to reset values, no done.
    run_job(0, 6, -1, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_job_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_job(0, 6, -1, 1'b1);

    // Randomized jobs.
    for (int i = 0; i < 20; i++) begin
      m   = int'($urandom_range(0, 3));
      ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 17)) : -1;
      tmp = model(m, 0, ovr);
      e   = ($urandom_range(0, 1) == 1) ? int'(tmp[5:2]) : int'($urandom_range(0, 15));
      run_job(m, e, ovr, 1'b1);
    end

    wait_idle(64);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_test_sequencer.md
Name: fsm_test_sequencer

Overview:
Controller that sequences one branch-decision FSM (the lab's x1/x2/x3 → result machine, 9 states, active-high async reset).
- Per requested job it resets the controlled FSM, holds the branch inputs for the selected path and counts cycles until `result` rises.
- It reports latency, timeout and pass/fail against an expected latency.
- It sits between the lab top/testbench and the controlled FSM instance.

Parameters:
- RST_CYCLES, 2: cycles `dut_reset` is held high at job start (≥1).
- TIMEOUT, 15: maximum RUN cycles before the job is declared timed out (≤ 2^CNT_W − 1).
- CNT_W, 4: width of the latency counter and of the latency ports.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- mode  in  2  path select, sampled with start: 0=A, 1=B, 2=C, 3=D.
- exp_lat  in  CNT_W  expected latency, sampled with start.
- busy  out  1  high in RESET, RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- latency  out  CNT_W  measured latency, held until next accepted start.
- timeout  out  1  last job hit TIMEOUT; held.
- pass  out  1  last job: !timeout && latency==exp_lat; held.
- dut_reset  out  1  active-high reset to controlled FSM.
- dut_x1, dut_x2, dut_x3  out  1 each  branch inputs to controlled FSM.
- dut_result  in  1  controlled FSM output.

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset values (reset_n=0):
  - state=IDLE; busy=0, done=0, latency=0, timeout=0, pass=0.
  - dut_reset=1 (controlled FSM held in reset); dut_x1/x2/x3=0.
- Mode → inputs (latched at start, driven through RESET and RUN, 0 in IDLE/DONE):
  - A: x1=0, x2=1, x3=0.
  - B: x1=1, x2=1, x3=0.
  - C: x1=0, x2=0, x3=1.
  - D: all 0 (stall path, never terminates).
- IDLE:
  - dut_reset=1.
  - start=1 → latch mode/exp_lat; clear latency/timeout/pass; rst counter=0; go RESET.
- RESET:
  - dut_reset=1 for exactly RST_CYCLES cycles.
  - Then go RUN; dut_reset=0 from the first RUN cycle; cycle counter cleared to 0.
- RUN, evaluated at each rising edge:
  - If dut_result==1'b1 (x/z count as not asserted): latency←counter, timeout←0, go DONE.
  - Else if counter==TIMEOUT: latency←TIMEOUT, timeout←1, go DONE.
  - Else counter←counter+1.
  - Result check has priority over the timeout check on the same edge.
- DONE:
  - done=1 for one cycle; pass←(!timeout && latency==exp_lat).
  - dut_reset returns to 1 and inputs return to 0; go IDLE.
- Latency with a conforming controlled FSM:
  - Controlled FSM leaves reset in its illegal state, then steps default→y0→y1→y2.
  - Expected latency: A=6, B=6, C=4, D=timeout (latency=15).
- start while busy: ignored, no queuing. start in the DONE cycle: ignored. start held high in IDLE: a new job starts every idle cycle.
- Mode and exp_lat changes while busy have no effect.
- reset_n asserted mid-job: immediate IDLE with all reset values; no done pulse.
- Counter never wraps: bounded by TIMEOUT ≤ 2^CNT_W − 1.
- All outputs are registered except `busy`, which is decoded from the state register.

Decomposition:
- Package `fsm_seq_pkg`:
  - State encoding: IDLE=0, RESET=1, RUN=2, DONE=3 (2-bit).
  - Mode codes MODE_A..MODE_D.
  - Mode→{x1,x2,x3} constant table.
- One natural sub-module, `fsm_run_timer`:
  - Inputs: clear, enable, TIMEOUT compare.
  - Outputs: count and at_limit.
  - Used for both the RESET hold count and the RUN latency count.

Test Plan:
1. reset_n low 3 cycles, then high → busy=0, dut_reset=1, latency=0, pass=0, dut_x*=0.
2. start, mode=0, exp_lat=6 → dut_x2=1 during job; dut_reset high 2 cycles; done pulse; latency=6, timeout=0, pass=1.
3. mode=1, exp_lat=6, then mode=2, exp_lat=5 → first: latency=6, pass=1; second: latency=4, pass=0.
4. mode=3, exp_lat=0 → done after TIMEOUT cycles; latency=15, timeout=1, pass=0.
5. Second start pulse mid-RUN, plus mode change → ignored; one done pulse only; latency matches first job.
6. reset_n low during RUN (mode 0) → immediate busy=0, dut_reset=1, outputs 0, no done; next start completes normally with latency=6.
